// File: rtl/i2c_slave_regfile_if.sv
// Pad-side and memory-side signals of the I2C register-file target.
interface i2c_slave_regfile_if #(
  parameter int PTR_W = 4
);
  logic             scl_in;
  logic             sda_in;
  logic             sda_oe;
  logic [PTR_W-1:0] mem_addr;
  logic [7:0]       mem_wdata;
  logic             mem_we;
  logic [7:0]       mem_rdata;
  logic             busy;

  modport slave (
    input  scl_in, sda_in, mem_rdata,
    output sda_oe, mem_addr, mem_wdata, mem_we, busy
  );
  modport master (
    output scl_in, sda_in, mem_rdata,
    input  sda_oe, mem_addr, mem_wdata, mem_we, busy
  );
endinterface

// File: rtl/i2c_slave_regfile.sv
// I2C target clocked from the system clock: oversampled, glitch-filtered SCL/SDA,
// auto-incrementing pointer into a synchronous-read register bank.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         MEM_DEPTH  = 16,
  parameter int         PTR_W      = $clog2(MEM_DEPTH),
  parameter int         FILTER_LEN = 3
) (
  input logic               clk,
  input logic               rst,
  i2c_slave_regfile_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  // Index 1 = SCL, index 0 = SDA
  logic [1:0]      raw;
  logic [1:0][1:0] sync;
  logic [1:0][2:0] fcnt;
  logic [1:0]      filt, filt_d;

  assign raw = {bus.scl_in, bus.sda_in};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync   <= '1;
      fcnt   <= '0;
      filt   <= '1;
      filt_d <= '1;
    end else begin
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        sync[i] <= {sync[i][0], raw[i]};
        if (sync[i][1] == filt[i])
          fcnt[i] <= '0;
        else if (fcnt[i] == 3'(FILTER_LEN - 1)) begin
          filt[i] <= sync[i][1];
          fcnt[i] <= '0;
        end else
          fcnt[i] <= fcnt[i] + 3'd1;
      end
    end
  end

  logic scl, sda, scl_rise, scl_fall, start, stop;
  assign scl      = filt[1];
  assign sda      = filt[0];
  assign scl_rise =  scl & ~filt_d[1];
  assign scl_fall = ~scl &  filt_d[1];
  assign start    = filt_d[1] & scl &  filt_d[0] & ~sda;
  assign stop     = filt_d[1] & scl & ~filt_d[0] &  sda;

  state_t           state, state_n;
  logic [PTR_W-1:0] ptr, ptr_n, ptr_inc;
  logic [7:0]       shreg, shreg_n, byte_in, wdata, wdata_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic             sda_oe, sda_oe_n, busy, busy_n, we, we_n;
  logic             rw, rw_n, acked, acked_n, inc_pend, inc_pend_n;

  assign ptr_inc = (ptr == PTR_W'(MEM_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  assign byte_in = {shreg[6:0], sda};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;    ptr <= '0;      shreg <= '0;  bit_cnt <= '0;
      sda_oe <= 1'b0;   busy <= 1'b0;   we <= 1'b0;   wdata <= '0;
      rw <= 1'b0;       acked <= 1'b0;  inc_pend <= 1'b0;
    end else begin
      state <= state_n; ptr <= ptr_n;     shreg <= shreg_n; bit_cnt <= bit_cnt_n;
      sda_oe <= sda_oe_n; busy <= busy_n; we <= we_n;       wdata <= wdata_n;
      rw <= rw_n;       acked <= acked_n; inc_pend <= inc_pend_n;
    end
  end

  always_comb begin
    state_n    = state;   ptr_n   = ptr;     shreg_n = shreg; bit_cnt_n = bit_cnt;
    sda_oe_n   = sda_oe;  busy_n  = busy;    we_n    = 1'b0;  wdata_n   = wdata;
    rw_n       = rw;      acked_n = acked;   inc_pend_n = 1'b0;
    // Post-write increment lands one clk after the strobe, even if a STOP follows
    if (inc_pend) ptr_n = ptr_inc;
    if (stop) begin
      state_n = IDLE; sda_oe_n = 1'b0; busy_n = 1'b0; bit_cnt_n = '0;
    end else if (start) begin
      state_n = ADDR; sda_oe_n = 1'b0; busy_n = 1'b0; bit_cnt_n = '0;
    end else begin
      case (state)
        ADDR, PTR, WR_DATA: if (scl_rise) begin
          shreg_n   = byte_in;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            bit_cnt_n = '0;
            if (state == ADDR) begin
              if (byte_in[7:1] == SLAVE_ADDR) begin
                state_n = ADDR_ACK; rw_n = byte_in[0]; busy_n = 1'b1;
              end else
                state_n = IGNORE;
            end else if (state == PTR) begin
              if ({1'b0, byte_in} < 9'(MEM_DEPTH)) begin
                ptr_n = byte_in[PTR_W-1:0]; state_n = PTR_ACK;
              end else
                state_n = IGNORE;
            end else begin
              we_n = 1'b1; wdata_n = byte_in; inc_pend_n = 1'b1; state_n = WR_ACK;
            end
          end
        end
        // ACK slots: first scl_fall pulls SDA low, the next one ends the slot
        ADDR_ACK, PTR_ACK, WR_ACK: if (scl_fall) begin
          if (!sda_oe)
            sda_oe_n = 1'b1;
          else if (state == ADDR_ACK && rw) begin
            state_n = RD_DATA; shreg_n = bus.mem_rdata;
            sda_oe_n = ~bus.mem_rdata[7]; bit_cnt_n = '0;
          end else begin
            sda_oe_n = 1'b0;
            state_n  = (state == ADDR_ACK) ? PTR : WR_DATA;
          end
        end
        RD_DATA: if (scl_fall) begin
          if (bit_cnt == 3'd7) begin
            sda_oe_n = 1'b0; bit_cnt_n = '0; acked_n = 1'b0; state_n = RD_ACK;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
            shreg_n   = {shreg[6:0], 1'b0};
            sda_oe_n  = ~shreg[6];
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            ptr_n = ptr_inc;
            if (sda) state_n = IGNORE;
            else     acked_n = 1'b1;
          end else if (scl_fall && acked) begin
            state_n = RD_DATA; shreg_n = bus.mem_rdata;
            sda_oe_n = ~bus.mem_rdata[7]; bit_cnt_n = '0;
          end
        end
        IGNORE:  sda_oe_n = 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.sda_oe    = sda_oe;
  assign bus.mem_addr  = ptr;
  assign bus.mem_wdata = wdata;
  assign bus.mem_we    = we;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bit-banged I2C master with write/read scoreboards against i2c_slave_regfile.
module tb_i2c_slave_regfile;
  localparam int DEPTH = 16;
  localparam int PW    = $clog2(DEPTH);
  localparam int H     = 16;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic m_scl = 1'b1, m_sda = 1'b1;
  i2c_slave_regfile_if #(.PTR_W(PW)) bus();
  i2c_slave_regfile #(.SLAVE_ADDR(7'h50), .MEM_DEPTH(DEPTH), .FILTER_LEN(3)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  assign bus.scl_in = m_scl;
  assign bus.sda_in = m_sda & ~bus.sda_oe;

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata;
  assign bus.mem_rdata = rdata;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      rdata <= 8'h00;
    end else begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      rdata <= mem[bus.mem_addr];
    end
  end

  int n_chk = 0, n_err = 0, oe_bad = 0, we_long = 0;
  logic oe_prev = 1'b0, we_prev = 1'b0, oe_seen = 1'b0;
  logic [PW+7:0] wq[$];
  logic [7:0]    rq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.sda_oe && !oe_prev && m_scl) oe_bad++;
    if (bus.sda_oe) oe_seen = 1'b1;
    if (bus.mem_we && we_prev) we_long++;
    if (bus.mem_we && !we_prev) begin
      if (wq.size() == 0) chk("we_unexp", 32'(bus.mem_we), 32'd0);
      else chk("wr", 32'({bus.mem_addr, bus.mem_wdata}), 32'(wq.pop_front()));
    end
    oe_prev = bus.sda_oe;
    we_prev = bus.mem_we;
  end

  task automatic hclk(input int n); repeat (n) @(negedge clk); endtask
  task automatic sbit(input logic b);
    m_sda = b; hclk(H); m_scl = 1'b1; hclk(H); m_scl = 1'b0; hclk(4);
  endtask
  task automatic rbit(output logic b);
    m_sda = 1'b1; hclk(H); m_scl = 1'b1; hclk(H/2); b = bus.sda_in; hclk(H/2);
    m_scl = 1'b0; hclk(4);
  endtask
  task automatic i2c_start;
    m_sda = 1'b1; hclk(H); m_scl = 1'b1; hclk(H); m_sda = 1'b0; hclk(H);
    m_scl = 1'b0; hclk(4);
  endtask
  task automatic i2c_stop;
    m_sda = 1'b0; hclk(H); m_scl = 1'b1; hclk(H); m_sda = 1'b1; hclk(H);
  endtask
  task automatic wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) sbit(d[i]);
    rbit(ack);
  endtask
  task automatic rbyte(output logic [7:0] d, input logic nack);
    for (int i = 7; i >= 0; i--) rbit(d[i]);
    sbit(nack);
  endtask
  task automatic rd_check(input string tag, input logic nack);
    logic [7:0] d;
    rbyte(d, nack);
    if (rq.size() == 0) chk({tag, "_unexp"}, 32'(d), 32'hFFFF_FFFF);
    else chk(tag, 32'(d), 32'(rq.pop_front()));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    logic ack;
    logic [7:0] pat;
    #1 rst = 1'b0;
    hclk(3);
    chk("rst_oe", 32'(bus.sda_oe), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_we", 32'(bus.mem_we), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_wdata", 32'(bus.mem_wdata), 0);
    rst = 1'b1;
    hclk(10);

    // Write burst at pointer 3
    i2c_start;
    wbyte(8'hA0, ack); chk("t1_aack", 32'(ack), 0);
    chk("t1_busy", 32'(bus.busy), 1);
    wbyte(8'h03, ack); chk("t1_pack", 32'(ack), 0);
    wq.push_back({4'd3, 8'h11}); wbyte(8'h11, ack); chk("t1_d0ack", 32'(ack), 0);
    wq.push_back({4'd4, 8'h22}); wbyte(8'h22, ack); chk("t1_d1ack", 32'(ack), 0);
    i2c_stop; hclk(4);
    chk("t1_busy_off", 32'(bus.busy), 0);
    chk("t1_ptr", 32'(bus.mem_addr), 5);

    // Pointer write, repeated START, two-byte read
    i2c_start;
    wbyte(8'hA0, ack); wbyte(8'h03, ack); chk("t2_pack", 32'(ack), 0);
    i2c_start;
    wbyte(8'hA1, ack); chk("t2_rack", 32'(ack), 0);
    rq.push_back(8'h11); rd_check("t2_rd0", 1'b0);
    rq.push_back(8'h22); rd_check("t2_rd1", 1'b1);
    hclk(4);
    chk("t2_release", 32'(bus.sda_oe), 0);
    i2c_stop;
    chk("t2_ptr", 32'(bus.mem_addr), 5);

    // Pointer wrap at the top of the space
    i2c_start;
    wbyte(8'hA0, ack); wbyte(8'h0F, ack);
    wq.push_back({4'd15, 8'hAA}); wbyte(8'hAA, ack);
    wq.push_back({4'd0, 8'hBB});  wbyte(8'hBB, ack);
    i2c_stop;
    chk("t3_ptr", 32'(bus.mem_addr), 1);

    // Foreign address is never acknowledged
    oe_seen = 1'b0;
    i2c_start;
    wbyte(8'h84, ack); chk("t4_nack", 32'(ack), 1);
    chk("t4_busy", 32'(bus.busy), 0);
    wbyte(8'h03, ack);
    i2c_stop;
    chk("t4_oe", 32'(oe_seen), 0);

    // Out-of-range pointer is rejected
    i2c_start;
    wbyte(8'hA0, ack); chk("t5_aack", 32'(ack), 0);
    wbyte(8'h20, ack); chk("t5_pnack", 32'(ack), 1);
    wbyte(8'h55, ack);
    i2c_stop;
    chk("t5_ptr", 32'(bus.mem_addr), 1);

    // Single-clk SCL glitch while SCL is low
    i2c_start;
    wbyte(8'hA0, ack); wbyte(8'h07, ack);
    m_scl = 1'b1; hclk(1); m_scl = 1'b0; hclk(4);
    wq.push_back({4'd7, 8'h5A}); wbyte(8'h5A, ack); chk("t6_gack", 32'(ack), 0);
    i2c_stop;

    // STOP after four data bits discards the partial byte
    i2c_start;
    wbyte(8'hA0, ack); wbyte(8'h09, ack);
    pat = 8'hC3;
    for (int i = 7; i >= 4; i--) sbit(pat[i]);
    i2c_stop; hclk(4);
    chk("t6_part_ptr", 32'(bus.mem_addr), 9);
    chk("t6_part_busy", 32'(bus.busy), 0);

    // Reset during the address ACK releases SDA immediately
    i2c_start;
    pat = 8'hA0;
    for (int i = 7; i >= 0; i--) sbit(pat[i]);
    for (int i = 0; i < 40 && !bus.sda_oe; i++) hclk(1);
    chk("t6_aack_oe", 32'(bus.sda_oe), 1);
    rst = 1'b0;
    #1;
    chk("t6_rst_oe", 32'(bus.sda_oe), 0);
    chk("t6_rst_busy", 32'(bus.busy), 0);
    chk("t6_rst_addr", 32'(bus.mem_addr), 0);
    m_scl = 1'b1; m_sda = 1'b1;
    hclk(3);
    rst = 1'b1;
    hclk(10);

    chk("wq_empty", 32'(wq.size()), 0);
    chk("rq_empty", 32'(rq.size()), 0);
    chk("oe_edge", 32'(oe_bad), 0);
    chk("we_width", 32'(we_long), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
